// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine: drives a req/ack data bus, formats load results,
// stalls the pipeline while a transaction is outstanding and reports access faults.
//
// state | meaning
// IDLE  | no transaction; accept, reject (fault) or ignore the presented op
// WAIT  | bus_req held with stable bus fields until ack, error or timeout
module mem_access_unit #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_op_valid,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] store_data,
  output logic            stall,
  output logic [XLEN-1:0] dm_read_data,
  output logic            load_valid,
  output logic            fault,
  output logic [1:0]      fault_code,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [3:0]      bus_be,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_ack,
  input  logic            bus_err,
  input  logic [XLEN-1:0] bus_rdata
);

  localparam logic [1:0] FC_MISALIGN = 2'd0;
  localparam logic [1:0] FC_ILLEGAL  = 2'd1;
  localparam logic [1:0] FC_BUS_ERR  = 2'd2;
  localparam logic [1:0] FC_TIMEOUT  = 2'd3;

  typedef enum logic {IDLE, WAIT} state_e;

  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            bus_req_q, bus_req_d;
  logic            bus_we_q, bus_we_d;
  logic [XLEN-1:0] bus_addr_q, bus_addr_d;
  logic [3:0]      bus_be_q, bus_be_d;
  logic [XLEN-1:0] bus_wdata_q, bus_wdata_d;
  logic [2:0]      fmt_f3_q, fmt_f3_d;
  logic [1:0]      fmt_off_q, fmt_off_d;
  logic [XLEN-1:0] dm_read_data_q, dm_read_data_d;
  logic            load_valid_q, load_valid_d;
  logic            fault_q, fault_d;
  logic [1:0]      fault_code_q, fault_code_d;

  logic            stall_c;
  logic            is_op, illegal, misaligned;
  logic [3:0]      be_c;
  logic [XLEN-1:0] wdata_c;
  logic [XLEN-1:0] lane;
  logic [XLEN-1:0] load_fmt;

  always_comb begin
    is_op      = mem_op_valid && (mem_read || mem_write);
    illegal    = (mem_read && mem_write)
              || (mem_read && (funct3 == 3'd3 || funct3[2:1] == 2'b11))
              || (mem_write && funct3 > 3'd2);
    misaligned = (funct3[1:0] == 2'b01 && addr[0])
              || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);

    be_c    = 4'hF;
    wdata_c = store_data;
    case (funct3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << addr[1:0];
        wdata_c = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_c    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{store_data[15:0]}};
      end
      default: ;
    endcase
    if (!mem_write) wdata_c = '0;
  end

  // Lane extraction uses the offset/width captured at request time, not the live inputs.
  always_comb begin
    lane = bus_rdata >> {fmt_off_q, 3'b000};
    case (fmt_f3_q)
      3'd0:    load_fmt = {{(XLEN-8){lane[7]}}, lane[7:0]};
      3'd1:    load_fmt = {{(XLEN-16){lane[15]}}, lane[15:0]};
      3'd4:    load_fmt = {{(XLEN-8){1'b0}}, lane[7:0]};
      3'd5:    load_fmt = {{(XLEN-16){1'b0}}, lane[15:0]};
      default: load_fmt = lane;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    bus_req_d      = bus_req_q;
    bus_we_d       = bus_we_q;
    bus_addr_d     = bus_addr_q;
    bus_be_d       = bus_be_q;
    bus_wdata_d    = bus_wdata_q;
    fmt_f3_d       = fmt_f3_q;
    fmt_off_d      = fmt_off_q;
    dm_read_data_d = dm_read_data_q;
    load_valid_d   = 1'b0;
    fault_d        = 1'b0;
    fault_code_d   = fault_code_q;
    stall_c        = 1'b0;

    case (state_q)
      IDLE: begin
        if (is_op) begin
          if (illegal) begin
            fault_d      = 1'b1;
            fault_code_d = FC_ILLEGAL;
          end else if (misaligned) begin
            fault_d      = 1'b1;
            fault_code_d = FC_MISALIGN;
          end else begin
            stall_c     = 1'b1;
            state_d     = WAIT;
            cnt_d       = '0;
            bus_req_d   = 1'b1;
            bus_we_d    = mem_write;
            bus_addr_d  = {addr[XLEN-1:2], 2'b00};
            bus_be_d    = be_c;
            bus_wdata_d = wdata_c;
            fmt_f3_d    = funct3;
            fmt_off_d   = addr[1:0];
          end
        end
      end
      WAIT: begin
        // An ack in the terminal-count cycle still completes the access.
        if (bus_ack) begin
          state_d   = IDLE;
          bus_req_d = 1'b0;
          if (bus_err) begin
            fault_d      = 1'b1;
            fault_code_d = FC_BUS_ERR;
          end else if (!bus_we_q) begin
            dm_read_data_d = load_fmt;
            load_valid_d   = 1'b1;
          end
        end else if (cnt_q == 8'(TIMEOUT)) begin
          state_d      = IDLE;
          bus_req_d    = 1'b0;
          fault_d      = 1'b1;
          fault_code_d = FC_TIMEOUT;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      bus_req_q      <= 1'b0;
      bus_we_q       <= 1'b0;
      bus_addr_q     <= '0;
      bus_be_q       <= '0;
      bus_wdata_q    <= '0;
      fmt_f3_q       <= '0;
      fmt_off_q      <= '0;
      dm_read_data_q <= '0;
      load_valid_q   <= 1'b0;
      fault_q        <= 1'b0;
      fault_code_q   <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      bus_req_q      <= bus_req_d;
      bus_we_q       <= bus_we_d;
      bus_addr_q     <= bus_addr_d;
      bus_be_q       <= bus_be_d;
      bus_wdata_q    <= bus_wdata_d;
      fmt_f3_q       <= fmt_f3_d;
      fmt_off_q      <= fmt_off_d;
      dm_read_data_q <= dm_read_data_d;
      load_valid_q   <= load_valid_d;
      fault_q        <= fault_d;
      fault_code_q   <= fault_code_d;
    end
  end

  // stall is combinational, so gate it with reset to release the pipeline immediately.
  assign stall        = stall_c & rst_n;
  assign bus_req      = bus_req_q;
  assign bus_we       = bus_we_q;
  assign bus_addr     = bus_addr_q;
  assign bus_be       = bus_be_q;
  assign bus_wdata    = bus_wdata_q;
  assign dm_read_data = dm_read_data_q;
  assign load_valid   = load_valid_q;
  assign fault        = fault_q;
  assign fault_code   = fault_code_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed plan cases plus randomized ops
// checked against an arithmetic reference model of the load/store rules.
module tb_mem_access_unit;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_op_valid, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        stall;
  logic [31:0] dm_read_data;
  logic        load_valid, fault;
  logic [1:0]  fault_code;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack, bus_err;
  logic [31:0] bus_rdata;

  int vectors = 0;
  int miscompares = 0;

  // observations of the most recent run_op
  int          obs_stall, obs_req, obs_flt, obs_lv, obs_unstable;
  bit          obs_hung;
  logic [1:0]  obs_code;
  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_be;
  logic        obs_we;

  logic [31:0] exp_dm;
  logic [1:0]  exp_code;

  mem_access_unit #(.XLEN(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_op_valid(mem_op_valid), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .store_data(store_data),
    .stall(stall), .dm_read_data(dm_read_data), .load_valid(load_valid),
    .fault(fault), .fault_code(fault_code),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int nbytes_of(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] w);
    int unsigned v, n;
    n = nbytes_of(f3);
    v = w >> (8 * a[1:0]);
    if (n < 4) begin
      v = v % (1 << (8 * n));
      if (f3 < 3'd4 && v >= (1 << (8 * n - 1))) v = v - (1 << (8 * n));
    end
    return v;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    int unsigned n;
    n = nbytes_of(f3);
    return 4'(((1 << n) - 1) << a[1:0]);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
    int unsigned n;
    n = nbytes_of(f3);
    if (n == 1) return (sd % 256) * 32'h0101_0101;
    if (n == 2) return (sd % 65536) * 32'h0001_0001;
    return sd;
  endfunction

  // 0 ignored, 1 illegal, 2 misaligned, 3 accepted
  function automatic int classify(input logic rd, input logic wr, input logic [2:0] f3,
                                  input logic [31:0] a);
    if (!rd && !wr) return 0;
    if (rd && wr) return 1;
    if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1;
    if (wr && f3 > 3'd2) return 1;
    if (a % nbytes_of(f3) != 0) return 2;
    return 3;
  endfunction

  // ---------------- stimulus driver ----------------
  // Presents one op, answers bus_req with ack on request cycle index 'lat', records what happens.
  task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd, input int lat,
                        input logic err, input logic [31:0] rdata);
    bit done;
    int idx;
    obs_stall = 0; obs_req = 0; obs_flt = 0; obs_lv = 0; obs_unstable = 0; obs_hung = 0;
    obs_code = fault_code;
    @(negedge clk);
    mem_op_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3;
    addr = a; store_data = sd; bus_ack = 1'b0; bus_err = 1'b0;
    #1;
    if (stall) obs_stall++;
    done = !stall;
    idx = 0;
    while (!done && idx < 200) begin
      @(negedge clk);
      bus_ack = 1'b0; bus_err = 1'b0;
      if (bus_req) begin
        if (obs_req == 0) begin
          obs_addr = bus_addr; obs_be = bus_be; obs_we = bus_we; obs_wdata = bus_wdata;
        end else if (bus_addr !== obs_addr || bus_be !== obs_be || bus_we !== obs_we ||
                     bus_wdata !== obs_wdata) begin
          obs_unstable++;
        end
        if (obs_req == lat) begin
          bus_ack = 1'b1; bus_err = err; bus_rdata = rdata;
        end
        obs_req++;
      end
      #1;
      if (stall) obs_stall++; else done = 1;
      if (fault) begin obs_flt++; obs_code = fault_code; end
      if (load_valid) obs_lv++;
      idx++;
    end
    if (!done) obs_hung = 1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      mem_op_valid = 1'b0; bus_ack = 1'b0; bus_err = 1'b0;
      #1;
      if (bus_req) obs_req++;
      if (fault) begin obs_flt++; obs_code = fault_code; end
      if (load_valid) obs_lv++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; mem_op_valid = 0; mem_read = 0; mem_write = 0; funct3 = 0;
    addr = 0; store_data = 0; bus_ack = 0; bus_err = 0; bus_rdata = 0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus_req, stall, load_valid, fault, bus_we} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got req/stall/lv/fault/we=%b expected 00000",
               {bus_req, stall, load_valid, fault, bus_we});
    end
    vectors++;
    if ({dm_read_data, bus_addr, bus_wdata, bus_be, fault_code} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got dm=%h addr=%h wdata=%h be=%h code=%0d expected all 0",
               dm_read_data, bus_addr, bus_wdata, bus_be, fault_code);
    end
    @(negedge clk); rst_n = 1'b1;
    exp_dm = 0; exp_code = 0;
  endtask

  task automatic test_load_word();
    run_op(1, 0, 3'd2, 32'h100, 32'h0, 3, 0, 32'hDEADBEEF);
    exp_dm = 32'hDEADBEEF;
    vectors++;
    if (obs_addr !== 32'h100 || obs_be !== 4'hF || obs_we !== 1'b0) begin
      miscompares++;
      $display("FAIL lw_bus: got addr=%h be=%h we=%b expected 00000100 f 0", obs_addr, obs_be, obs_we);
    end
    vectors++;
    if (obs_stall != 4) begin
      miscompares++; $display("FAIL lw_stall: got %0d stall cycles expected 4", obs_stall);
    end
    vectors++;
    if (dm_read_data !== 32'hDEADBEEF || obs_lv != 1) begin
      miscompares++;
      $display("FAIL lw_data: got dm=%h lv=%0d expected deadbeef 1", dm_read_data, obs_lv);
    end
  endtask

  task automatic test_subword_loads();
    logic [2:0]  f3s [3] = '{3'd0, 3'd4, 3'd5};
    logic [31:0] as  [3] = '{32'h103, 32'h103, 32'h102};
    logic [31:0] exps[3] = '{32'hFFFFFF80, 32'h00000080, 32'h00008011};
    logic [3:0]  bes [3] = '{4'b1000, 4'b1000, 4'b1100};
    for (int i = 0; i < 3; i++) begin
      run_op(1, 0, f3s[i], as[i], 32'h0, 1, 0, 32'h80112233);
      exp_dm = exps[i];
      vectors++;
      if (dm_read_data !== exps[i] || obs_be !== bes[i] || obs_lv != 1) begin
        miscompares++;
        $display("FAIL subword_load%0d: got dm=%h be=%b lv=%0d expected %h %b 1",
                 i, dm_read_data, obs_be, obs_lv, exps[i], bes[i]);
      end
    end
  endtask

  task automatic test_store_half();
    run_op(0, 1, 3'd1, 32'h206, 32'h1234ABCD, 2, 0, 32'hFFFFFFFF);
    vectors++;
    if (obs_addr !== 32'h204 || obs_be !== 4'b1100 || obs_wdata !== 32'hABCDABCD || obs_we !== 1'b1) begin
      miscompares++;
      $display("FAIL sh_bus: got addr=%h be=%b wdata=%h we=%b expected 00000204 1100 abcdabcd 1",
               obs_addr, obs_be, obs_wdata, obs_we);
    end
    vectors++;
    if (obs_lv != 0 || dm_read_data !== exp_dm) begin
      miscompares++;
      $display("FAIL sh_noload: got lv=%0d dm=%h expected 0 %h", obs_lv, dm_read_data, exp_dm);
    end
  endtask

  task automatic test_faults();
    run_op(1, 0, 3'd2, 32'h101, 32'h0, 0, 0, 32'h0);
    vectors++;
    if (obs_flt != 1 || obs_code !== 2'd0 || obs_req != 0 || obs_stall != 0) begin
      miscompares++;
      $display("FAIL misaligned: got flt=%0d code=%0d req=%0d stall=%0d expected 1 0 0 0",
               obs_flt, obs_code, obs_req, obs_stall);
    end
    run_op(1, 0, 3'd3, 32'h100, 32'h0, 0, 0, 32'h0);
    vectors++;
    if (obs_flt != 1 || obs_code !== 2'd1 || obs_req != 0 || obs_stall != 0) begin
      miscompares++;
      $display("FAIL illegal: got flt=%0d code=%0d req=%0d stall=%0d expected 1 1 0 0",
               obs_flt, obs_code, obs_req, obs_stall);
    end
  endtask

  task automatic test_timeout_and_err();
    run_op(1, 0, 3'd2, 32'h300, 32'h0, 1000, 0, 32'h0);
    vectors++;
    if (obs_hung || obs_flt != 1 || obs_code !== 2'd3 || obs_req != TO + 1 || obs_stall != TO + 1) begin
      miscompares++;
      $display("FAIL timeout: got hung=%0d flt=%0d code=%0d req=%0d stall=%0d expected 0 1 3 %0d %0d",
               obs_hung, obs_flt, obs_code, obs_req, obs_stall, TO + 1, TO + 1);
    end
    run_op(1, 0, 3'd2, 32'h304, 32'h0, TO, 0, 32'h13579BDF);
    exp_dm = 32'h13579BDF;
    vectors++;
    if (obs_flt != 0 || obs_lv != 1 || dm_read_data !== exp_dm) begin
      miscompares++;
      $display("FAIL ack_at_limit: got flt=%0d lv=%0d dm=%h expected 0 1 %h",
               obs_flt, obs_lv, dm_read_data, exp_dm);
    end
    run_op(1, 0, 3'd2, 32'h308, 32'h0, 2, 1, 32'h55555555);
    vectors++;
    if (obs_flt != 1 || obs_code !== 2'd2 || obs_lv != 0 || dm_read_data !== exp_dm) begin
      miscompares++;
      $display("FAIL bus_err: got flt=%0d code=%0d lv=%0d dm=%h expected 1 2 0 %h",
               obs_flt, obs_code, obs_lv, dm_read_data, exp_dm);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      int          sel, cls, lat, exp_req;
      logic        rd, wr, err;
      logic [2:0]  f3;
      logic [31:0] a, sd, rdat;
      sel  = $urandom_range(0, 7);
      rd   = (sel == 1) || (sel >= 2 && sel <= 4);
      wr   = (sel == 1) || (sel >= 5);
      f3   = 3'($urandom_range(0, 7));
      a    = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      sd   = $urandom;
      rdat = $urandom;
      lat  = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 5);
      err  = ($urandom_range(0, 7) == 0);
      cls  = classify(rd, wr, f3, a);
      run_op(rd, wr, f3, a, sd, lat, err, rdat);

      exp_req = (cls == 3) ? ((lat <= TO) ? lat + 1 : TO + 1) : 0;
      vectors++;
      if (obs_hung || obs_req != exp_req || obs_stall != exp_req) begin
        miscompares++;
        $display("FAIL rnd%0d_handshake: got hung=%0d req=%0d stall=%0d expected 0 %0d %0d",
                 n, obs_hung, obs_req, obs_stall, exp_req, exp_req);
      end

      if (cls == 1) exp_code = 2'd1;
      else if (cls == 2) exp_code = 2'd0;
      else if (cls == 3 && lat > TO) exp_code = 2'd3;
      else if (cls == 3 && err) exp_code = 2'd2;
      vectors++;
      if (obs_flt != ((cls == 1 || cls == 2 || (cls == 3 && (lat > TO || err))) ? 1 : 0) ||
          obs_code !== exp_code) begin
        miscompares++;
        $display("FAIL rnd%0d_fault: got flt=%0d code=%0d expected code %0d (class %0d)",
                 n, obs_flt, obs_code, exp_code, cls);
      end

      if (cls == 3) begin
        vectors++;
        if (obs_addr !== {a[31:2], 2'b00} || obs_be !== model_be(f3, a) || obs_we !== wr ||
            obs_wdata !== (wr ? model_wdata(f3, sd) : 32'h0) || obs_unstable != 0) begin
          miscompares++;
          $display("FAIL rnd%0d_bus: got addr=%h be=%b we=%b wdata=%h unstable=%0d expected %h %b %b %h 0",
                   n, obs_addr, obs_be, obs_we, obs_wdata, obs_unstable, {a[31:2], 2'b00},
                   model_be(f3, a), wr, wr ? model_wdata(f3, sd) : 32'h0);
        end
        if (rd && lat <= TO && !err) exp_dm = model_load(f3, a, rdat);
      end
      vectors++;
      if (dm_read_data !== exp_dm ||
          obs_lv != ((cls == 3 && rd && lat <= TO && !err) ? 1 : 0)) begin
        miscompares++;
        $display("FAIL rnd%0d_load: got dm=%h lv=%0d expected %h (f3=%0d addr=%h)",
                 n, dm_read_data, obs_lv, exp_dm, f3, a);
      end
    end
  endtask

  task automatic test_reset_mid();
    int k;
    run_op(1, 0, 3'd2, 32'h40, 32'h0, 0, 0, 32'hCAFEF00D);
    exp_dm = 32'hCAFEF00D;
    @(negedge clk);
    mem_op_valid = 1; mem_read = 1; mem_write = 0; funct3 = 3'd2; addr = 32'h80;
    bus_ack = 0; bus_err = 0;
    k = 0;
    do begin @(negedge clk); k++; end while (!bus_req && k < 10);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (bus_req !== 1'b0 || stall !== 1'b0 || dm_read_data !== 32'h0 || k >= 10) begin
      miscompares++;
      $display("FAIL reset_mid: got req=%b stall=%b dm=%h wait=%0d expected 0 0 00000000 <10",
               bus_req, stall, dm_read_data, k);
    end
    @(negedge clk);
    mem_op_valid = 0;
    rst_n = 1'b1;
    exp_dm = 0;
    run_op(1, 0, 3'd2, 32'h84, 32'h0, 2, 0, 32'h0BADCAFE);
    exp_dm = 32'h0BADCAFE;
    vectors++;
    if (dm_read_data !== exp_dm || obs_lv != 1 || obs_flt != 0 || obs_stall != 3) begin
      miscompares++;
      $display("FAIL after_reset_lw: got dm=%h lv=%0d flt=%0d stall=%0d expected %h 1 0 3",
               dm_read_data, obs_lv, obs_flt, obs_stall, exp_dm);
    end
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_subword_loads();
    test_store_half();
    test_faults();
    test_timeout_and_err();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
